// File: rtl/phased_counter_pkg.sv
// Shared phase encoding and compare helpers for the phased counter engine.
// Latency: none (types and constant functions only).
// Backpressure: none.
package phased_counter_pkg;

   typedef enum logic [1:0] {
      RUN1_E = 2'd0,
      RUN2_E = 2'd1,
      DONE_E = 2'd2
   } phase_e;

   localparam logic [1:0] PH_RUN1 = RUN1_E;
   localparam logic [1:0] PH_RUN2 = RUN2_E;
   localparam logic [1:0] PH_DONE = DONE_E;

   // True when v+1 equals target. The 64-bit arithmetic is always wider than
   // W+1, so the increment can never wrap back onto a small target.
   function automatic logic inc_reaches(input longint unsigned v,
                                        input longint unsigned target);
      return (v + 64'd1) == target;
   endfunction

   // Phase entered on reset/reload: an init value already at the switch
   // point skips the x-only phase.
   function automatic logic [1:0] start_phase(input longint unsigned x_init,
                                              input longint unsigned x_switch);
      return (x_init >= x_switch) ? PH_RUN2 : PH_RUN1;
   endfunction

endpackage

// File: rtl/phased_counter_n_if.sv
// Control/status bundle between a phased counter and its controller.
// Latency: none (wires only).
// Backpressure: none; the controller drives controls, the counter drives status.
interface phased_counter_n_if
   import phased_counter_pkg::*;
#(
   parameter int W   = 11,
   parameter int NCH = 2
);
   logic             selector;
   logic             restart;
   logic             auto_reload;
   logic [NCH-1:0]   ch_en;
   logic [W-1:0]     x;
   logic [NCH*W-1:0] y;
   logic [1:0]       phase;
   logic             done;

   modport master (
      output selector, restart, auto_reload, ch_en,
      input  x, y, phase, done
   );

   modport slave (
      input  selector, restart, auto_reload, ch_en,
      output x, y, phase, done
   );
endinterface

// File: rtl/phased_counter_chan.sv
// One y channel: saturating counter with latched participation bit.
// Latency: 1 cycle from step/load to y; active flags are combinational.
// Backpressure: none; holds whenever step is low or the channel is inactive.
module phased_counter_chan
   import phased_counter_pkg::*;
#(
   parameter int W       = 11,
   parameter int Y_INIT  = 100,
   parameter int Y_LIMIT = 200
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         fresh,
   input  logic         load,
   input  logic         step,
   input  logic         mask_in,
   output logic [W-1:0] y,
   output logic         active,
   output logic         active_next
);
   localparam logic [W-1:0] Y_INIT_W  = W'(Y_INIT);
   localparam logic [W:0]   Y_LIMIT_X = (W+1)'(Y_LIMIT);

   logic       mask_q;
   logic       mask;
   logic [W:0] y_inc;

   // Right after reset the mask register has not captured ch_en yet, so the
   // live input stands in for it during that first cycle.
   assign mask        = fresh ? mask_in : mask_q;
   assign y_inc       = {1'b0, y} + (W+1)'(1);
   assign active      = mask && ({1'b0, y} < Y_LIMIT_X);
   assign active_next = active && (y_inc < Y_LIMIT_X);

   // Channel value and participation bit; mask only changes at reset/reload.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y      <= Y_INIT_W;
         mask_q <= 1'b0;
      end else begin
         if (load || fresh) begin
            mask_q <= mask_in;
         end
         if (load) begin
            y <= Y_INIT_W;
         end else if (step && active) begin
            y <= y_inc[W-1:0];
         end
      end
   end
endmodule

// File: rtl/phased_counter_n.sv
// Two-phase counter: x alone up to X_SWITCH, then x plus masked y channels.
// Latency: 1 cycle from an enabled edge to x/y/phase/done.
// Backpressure: selector=0 freezes all state; restart and auto-reload ignore it.
module phased_counter_n
   import phased_counter_pkg::*;
#(
   parameter int W        = 11,
   parameter int NCH      = 2,
   parameter int X_INIT   = 0,
   parameter int X_SWITCH = 100,
   parameter int X_LIMIT  = 200,
   parameter int Y_INIT   = 100,
   parameter int Y_LIMIT  = 200
)
(
   input  logic               clk,
   input  logic               rst,
   phased_counter_n_if.slave  bus
);
   if (!(W >= 1 && W <= 62 && NCH >= 1 &&
         X_INIT >= 0 && X_INIT <= X_SWITCH && X_SWITCH < X_LIMIT &&
         64'(X_LIMIT) < (64'd1 << W) &&
         Y_INIT >= 0 && Y_INIT <= Y_LIMIT &&
         64'(Y_LIMIT) < (64'd1 << W))) begin : g_bad_params
      $error("phased_counter_n: illegal parameter combination");
   end

   localparam logic [W-1:0] X_INIT_W  = W'(X_INIT);
   localparam logic [W:0]   X_LIMIT_X = (W+1)'(X_LIMIT);
   localparam logic [1:0]   PH_START  = start_phase(64'(X_INIT), 64'(X_SWITCH));

   logic [W-1:0]   x;
   logic [1:0]     state;
   logic           fresh;
   logic [W:0]     x_inc;
   logic           reload;
   logic           run2_go;
   logic           step;
   logic [NCH-1:0] active;
   logic [NCH-1:0] active_next;
   logic [W-1:0]   y_ch [NCH];
   logic [NCH*W-1:0] y_pack;

   assign x_inc   = {1'b0, x} + (W+1)'(1);
   assign reload  = bus.restart || (state == PH_DONE && bus.auto_reload);
   assign run2_go = ({1'b0, x} < X_LIMIT_X) && (|active);
   assign step    = !reload && (state == PH_RUN2) && bus.selector && run2_go;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      phased_counter_chan #(
         .W       (W),
         .Y_INIT  (Y_INIT),
         .Y_LIMIT (Y_LIMIT)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .fresh       (fresh),
         .load        (reload),
         .step        (step),
         .mask_in     (bus.ch_en[i]),
         .y           (y_ch[i]),
         .active      (active[i]),
         .active_next (active_next[i])
      );
   end

   // Marks the first cycle after reset so channels capture ch_en on that edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fresh <= 1'b1;
      end else begin
         fresh <= 1'b0;
      end
   end

   // x register and phase FSM; phase moves on the same edge as the update causing it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x     <= X_INIT_W;
         state <= PH_START;
      end else if (reload) begin
         x     <= X_INIT_W;
         state <= PH_START;
      end else if (bus.selector) begin
         case (state)
            PH_RUN1: begin
               x <= x_inc[W-1:0];
               if (inc_reaches(64'(x), 64'(X_SWITCH))) begin
                  state <= PH_RUN2;
               end
            end
            PH_RUN2: begin
               if (run2_go) begin
                  x <= x_inc[W-1:0];
                  if (x_inc == X_LIMIT_X || !(|active_next)) begin
                     state <= PH_DONE;
                  end
               end else begin
                  // Nothing left to advance (all channels masked or saturated).
                  state <= PH_DONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Flatten channel values onto the status bus, channel i at [i*W +: W].
   always_comb begin
      y_pack = '0;
      for (int i = 0; i < NCH; i++) begin
         y_pack[i*W +: W] = y_ch[i];
      end
   end

   assign bus.x     = x;
   assign bus.y     = y_pack;
   assign bus.phase = state;
   assign bus.done  = (state == PH_DONE);
endmodule

// File: tb/tb_phased_counter_n.sv
// Self-checking bench for phased_counter_n: vector table, corner sequences,
// randomized run against a rule-level model, and a narrow-width instance.
module tb_phased_counter_n;
   localparam int W        = 11;
   localparam int NCH      = 2;
   localparam int X_INIT   = 0;
   localparam int X_SWITCH = 100;
   localparam int X_LIMIT  = 200;
   localparam int Y_INIT   = 100;
   localparam int Y_LIMIT  = 200;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   phased_counter_n_if #(.W(W), .NCH(NCH)) bus ();
   phased_counter_n_if #(.W(8), .NCH(2))   sbus ();

   phased_counter_n #(
      .W(W), .NCH(NCH), .X_INIT(X_INIT), .X_SWITCH(X_SWITCH),
      .X_LIMIT(X_LIMIT), .Y_INIT(Y_INIT), .Y_LIMIT(Y_LIMIT)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   phased_counter_n #(
      .W(8), .NCH(2), .X_INIT(0), .X_SWITCH(100),
      .X_LIMIT(255), .Y_INIT(100), .Y_LIMIT(255)
   ) u_small (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input bit rs, input bit ar, input bit [1:0] en);
      bus.selector    = sel;
      bus.restart     = rs;
      bus.auto_reload = ar;
      bus.ch_en       = en;
   endtask

   task automatic compare_all(input string tag, input int ex, input int ey0,
                              input int ey1, input int eph, input bit ed);
      check({tag, "_x"},     64'(bus.x),         64'(ex));
      check({tag, "_y0"},    64'(bus.y[0 +: W]), 64'(ey0));
      check({tag, "_y1"},    64'(bus.y[W +: W]), 64'(ey1));
      check({tag, "_phase"}, 64'(bus.phase),     64'(eph));
      check({tag, "_done"},  64'(bus.done),      64'(ed));
   endtask

   // ---------------- reference model (rule level) ----------------
   int         m_x;
   int         m_phase;
   int         m_y [NCH];
   bit [NCH-1:0] m_mask;

   function automatic int open_channels();
      int n = 0;
      for (int i = 0; i < NCH; i++)
         if (m_mask[i] && m_y[i] < Y_LIMIT) n++;
      return n;
   endfunction

   task automatic model_edge(input bit sel, input bit rs, input bit ar, input bit [NCH-1:0] en);
      if (rs || (m_phase == 2 && ar)) begin
         m_x = X_INIT;
         for (int i = 0; i < NCH; i++) m_y[i] = Y_INIT;
         m_mask  = en;
         m_phase = (X_INIT >= X_SWITCH) ? 1 : 0;
      end else if (sel && m_phase == 0) begin
         m_x = m_x + 1;
         if (m_x == X_SWITCH) m_phase = 1;
      end else if (sel && m_phase == 1) begin
         if (m_x >= X_LIMIT || open_channels() == 0) begin
            m_phase = 2;
         end else begin
            for (int i = 0; i < NCH; i++)
               if (m_mask[i] && m_y[i] < Y_LIMIT) m_y[i] = m_y[i] + 1;
            m_x = m_x + 1;
            if (m_x == X_LIMIT || open_channels() == 0) m_phase = 2;
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int     cycles;
      bit     sel;
      bit     rs;
      bit     ar;
      bit [1:0] en;
      int     ex;
      int     ey0;
      int     ey1;
      int     eph;
      bit     edone;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int k;
      int ex;
      int ey;
      bit s;
      bit r;
      bit a;
      bit [1:0] e;

      tbl[0]  = '{100, 1, 0, 0, 2'b11, 100, 100, 100, 1, 0};
      tbl[1]  = '{ 50, 1, 0, 0, 2'b11, 150, 150, 150, 1, 0};
      tbl[2]  = '{  5, 0, 0, 0, 2'b11, 150, 150, 150, 1, 0};
      tbl[3]  = '{  1, 1, 1, 0, 2'b11,   0, 100, 100, 0, 0};
      tbl[4]  = '{200, 1, 0, 0, 2'b11, 200, 200, 200, 2, 1};
      tbl[5]  = '{ 20, 1, 0, 0, 2'b11, 200, 200, 200, 2, 1};
      tbl[6]  = '{  1, 0, 1, 0, 2'b01,   0, 100, 100, 0, 0};
      tbl[7]  = '{200, 1, 0, 0, 2'b11, 200, 200, 100, 2, 1};
      tbl[8]  = '{  1, 1, 1, 0, 2'b00,   0, 100, 100, 0, 0};
      tbl[9]  = '{100, 1, 0, 0, 2'b00, 100, 100, 100, 1, 0};
      tbl[10] = '{  1, 1, 0, 0, 2'b00, 100, 100, 100, 2, 1};
      tbl[11] = '{  3, 0, 0, 1, 2'b11,   0, 100, 100, 0, 0};
      tbl[12] = '{200, 1, 0, 0, 2'b11, 200, 200, 200, 2, 1};

      rst = 1'b0;
      drive(0, 0, 0, 2'b11);
      sbus.selector = 1'b0; sbus.restart = 1'b0; sbus.auto_reload = 1'b0; sbus.ch_en = 2'b11;
      #12;
      compare_all("reset", 0, 100, 100, 0, 0);
      check("small_reset_x", 64'(sbus.x), 64'd0);
      rst = 1'b1;

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].sel, tbl[i].rs, tbl[i].ar, tbl[i].en);
         tick(tbl[i].cycles);
         compare_all($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey0, tbl[i].ey1,
                     tbl[i].eph, tbl[i].edone);
      end

      // selector toggled every cycle: only enabled edges count
      drive(0, 1, 0, 2'b11);
      tick(1);
      k = 0;
      for (int i = 0; i < 400; i++) begin
         drive(i % 2 == 0, 0, 0, 2'b11);
         tick(1);
         if (i % 2 == 0) k++;
         ex = (k < X_LIMIT) ? k : X_LIMIT;
         ey = Y_INIT + ((ex > X_SWITCH) ? ex - X_SWITCH : 0);
         check("toggle_x", 64'(bus.x), 64'(ex));
         check("toggle_y1", 64'(bus.y[W +: W]), 64'(ey));
         check("toggle_done", 64'(bus.done), 64'(k >= X_LIMIT));
      end

      // auto_reload held: one DONE cycle, then reload, twice
      drive(1, 1, 1, 2'b11);
      tick(1);
      drive(1, 0, 1, 2'b11);
      for (int run = 0; run < 2; run++) begin
         tick(199);
         compare_all("ar_pre", 199, 199, 199, 1, 0);
         tick(1);
         compare_all("ar_done", 200, 200, 200, 2, 1);
         tick(1);
         compare_all("ar_reload", 0, 100, 100, 0, 0);
      end

      // asynchronous reset in the middle of a cycle
      drive(1, 1, 0, 2'b11);
      tick(1);
      drive(1, 0, 0, 2'b11);
      tick(120);
      compare_all("pre_areset", 120, 120, 120, 1, 0);
      #3;
      rst = 1'b0;
      #1;
      compare_all("areset", 0, 100, 100, 0, 0);
      drive(0, 0, 0, 2'b11);
      #2;
      rst = 1'b1;

      // randomized stimulus against the model
      m_x = 0; m_phase = 0; m_mask = '0;
      for (int i = 0; i < NCH; i++) m_y[i] = 0;
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom_range(0, 3) != 0);
         r = (i == 0) || ($urandom_range(0, 199) == 0);
         a = ($urandom_range(0, 1) == 1);
         e = 2'($urandom_range(0, 3));
         drive(s, r, a, e);
         tick(1);
         model_edge(s, r, a, e);
         compare_all("rand", m_x, m_y[0], m_y[1], m_phase, m_phase == 2);
         for (int c = 0; c < NCH; c++)
            if (m_mask[c])
               check("rand_invariant", 64'(bus.y[c*W +: W]),
                     64'(Y_INIT + ((m_x > X_SWITCH) ? m_x - X_SWITCH : 0)));
      end
      drive(0, 0, 0, 2'b11);

      // narrow instance: x must saturate at 2^W-1 without wrapping
      sbus.selector = 1'b1;
      tick(254);
      check("small_x_254", 64'(sbus.x), 64'd254);
      check("small_y0_254", 64'(sbus.y[0 +: 8]), 64'd254);
      check("small_done_254", 64'(sbus.done), 64'd0);
      tick(1);
      check("small_x_255", 64'(sbus.x), 64'd255);
      check("small_y1_255", 64'(sbus.y[8 +: 8]), 64'd255);
      check("small_phase_255", 64'(sbus.phase), 64'd2);
      check("small_done_255", 64'(sbus.done), 64'd1);
      tick(10);
      check("small_x_hold", 64'(sbus.x), 64'd255);
      check("small_done_hold", 64'(sbus.done), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
